// File: rtl/seq_cla_adder.sv
// Multi-cycle adder: one SLICE-bit carry-lookahead slice per clock, N = WIDTH/SLICE cycles per sum.
// Optional subtraction (a - b) is enabled by defining SEQ_CLA_ADDER_SUB_EN.
module seq_cla_adder #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_CLA_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("seq_cla_adder: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_next;
  logic [KW-1:0]    k_reg;
  logic             carry_reg, cout_reg;
  logic             accept, step;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

`ifdef SEQ_CLA_ADDER_SUB_EN
  // a - b computed as a + ~b + 1; cout=1 then means no borrow
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (k_reg == K_LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right each step, so the active slice is always the low SLICE bits
  logic [SLICE-1:0] p, g, s_slice;
  logic [SLICE:0]   c_vec;

  assign p        = a_reg[SLICE-1:0] ^ b_reg[SLICE-1:0];
  assign g        = a_reg[SLICE-1:0] & b_reg[SLICE-1:0];
  assign c_vec[0] = carry_reg;

  for (genvar gi = 0; gi < SLICE; gi++) begin : g_carry
    localparam logic [SLICE-1:0] SPAN = {SLICE{1'b1}} >> (SLICE - 1 - gi);
    logic [SLICE-1:0] term;
    // Two-level lookahead: carry into bit gi+1 = OR of g[j] propagated through p[j+1..gi]
    for (genvar gj = 0; gj < SLICE; gj++) begin : g_term
      if (gj <= gi) begin : g_on
        localparam logic [SLICE-1:0] PMASK = SPAN & ({SLICE{1'b1}} << (gj + 1));
        assign term[gj] = g[gj] & (&(p | ~PMASK));
      end else begin : g_off
        assign term[gj] = 1'b0;
      end
    end
    assign c_vec[gi+1] = (|term) | ((&(p | ~SPAN)) & carry_reg);
    assign s_slice[gi] = p[gi] ^ c_vec[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_sum
    assign sum_next[gi*SLICE +: SLICE] = (k_reg == KW'(gi)) ? s_slice
                                                            : sum_reg[gi*SLICE +: SLICE];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      k_reg     <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= b_cap;
      sum_reg   <= '0;
      k_reg     <= '0;
      carry_reg <= c_cap;
      cout_reg  <= 1'b0;
    end else if (step) begin
      a_reg     <= a_reg >> SLICE;
      b_reg     <= b_reg >> SLICE;
      sum_reg   <= sum_next;
      carry_reg <= c_vec[SLICE];
      k_reg     <= (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
      if (k_reg == K_LAST) cout_reg <= c_vec[SLICE];
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
